// File: rtl/fc_result_reader_pkg.sv
// fc_result_reader_pkg: FSM state encoding and clog2 helper shared with the FC layer and loaders
package fc_result_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fc_argmax_step.sv
// fc_argmax_step: one signed argmax step, keeps the incumbent on ties so the lowest index wins
module fc_argmax_step #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [DATA_WIDTH-1:0] best,
  input  logic [IDX_WIDTH-1:0]  best_idx,
  input  logic [DATA_WIDTH-1:0] elem,
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [DATA_WIDTH-1:0] next_best,
  output logic [IDX_WIDTH-1:0]  next_idx
);

  logic take;

  assign take      = $signed(elem) > $signed(best);
  assign next_best = take ? elem : best;
  assign next_idx  = take ? idx : best_idx;

endmodule

// File: rtl/fc_result_reader.sv
// fc_result_reader: captures an FC result vector, finds its signed argmax and streams the scores
module fc_result_reader
  import fc_result_reader_pkg::*;
#(
  parameter int OUTPUT_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                              busy,
  output logic                              class_valid,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_score,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [IDX_WIDTH-1:0]              m_index,
  output logic                              m_last,
  output logic                              overrun,
  input  logic                              clr_overrun
);

  localparam int W = OUTPUT_SIZE * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(OUTPUT_SIZE - 1);

  state_t                state, state_d;
  logic [IDX_WIDTH-1:0]  cnt, cnt_d, best_idx, best_idx_d, step_idx, class_idx_d;
  logic [DATA_WIDTH-1:0] best, best_d, step_best, elem, class_score_d;
  logic [W-1:0]          buffer, buffer_d;
  logic                  class_valid_d, overrun_d, at_last, stream;

  assign elem    = buffer[cnt*DATA_WIDTH +: DATA_WIDTH];
  assign at_last = cnt == LAST;
  assign stream  = state == STREAM;
  assign busy    = state != IDLE;
  assign m_valid = stream;
  assign m_data  = stream ? elem : '0;
  assign m_index = stream ? cnt : '0;
  assign m_last  = stream && at_last;

  fc_argmax_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_step (
    .best     (best),
    .best_idx (best_idx),
    .elem     (elem),
    .idx      (cnt),
    .next_best(step_best),
    .next_idx (step_idx)
  );

  // next-state: capture in IDLE, one compare per SCAN cycle, advance beats on handshake
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    buffer_d      = buffer;
    best_d        = best;
    best_idx_d    = best_idx;
    class_valid_d = 1'b0;
    class_idx_d   = class_idx;
    class_score_d = class_score;
    overrun_d     = (in_valid && busy) || (overrun && !clr_overrun);
    case (state)
      IDLE: if (in_valid) begin
        buffer_d   = in_data;
        best_d     = in_data[DATA_WIDTH-1:0];
        best_idx_d = '0;
        cnt_d      = '0;
        state_d    = SCAN;
      end
      SCAN: begin
        best_d     = step_best;
        best_idx_d = step_idx;
        cnt_d      = at_last ? '0 : cnt + 1'b1;
        if (at_last) begin
          state_d       = STREAM;
          class_valid_d = 1'b1;
          class_idx_d   = step_idx;
          class_score_d = step_best;
        end
      end
      STREAM: if (m_ready) begin
        cnt_d   = at_last ? '0 : cnt + 1'b1;
        state_d = at_last ? IDLE : STREAM;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      buffer      <= '0;
      best        <= '0;
      best_idx    <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      buffer      <= buffer_d;
      best        <= best_d;
      best_idx    <= best_idx_d;
      class_valid <= class_valid_d;
      class_idx   <= class_idx_d;
      class_score <= class_score_d;
      overrun     <= overrun_d;
    end
  end

endmodule
